fir_stream_ctrl: RTL and testbench

Streaming controller for the systolic FIR chain built from `dsp_slice` instances. It sits at both ends of the slice chain:
- Front: accepts 4-bit samples over a valid/ready handshake, drives the first slice, and holds the per-tap coefficient registers.
- Back: collects the last slice's 12-bit accumulator, tags it valid after the fixed chain latency, rounds and saturates it to 8 bits, and buffers it in a small output FIFO with valid/ready backpressure.

Credit-based input throttling guarantees that no tagged result is ever dropped, even though the chain itself is free-running and cannot stall.

---
 rtl/fir_stream_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fir_stream_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_ctrl.sv
// Stream controller at both ends of the systolic dsp_slice FIR chain.
// Input credits keep every tagged result inside the output FIFO.
module fir_stream_ctrl #(
   parameter int unsigned TAPS    = 4,
   parameter int unsigned LATENCY = 7,
   parameter int unsigned SHIFT   = 2,
   parameter int unsigned DEPTH   = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [3:0]          in_sample,
   output logic [3:0]          chain_sample,
   output logic [11:0]         chain_accum,
   input  logic [11:0]         chain_accum_ret,
   output logic [8*TAPS-1:0]   coeff_bus,
   input  logic                cfg_we,
   input  logic [2:0]          cfg_addr,
   input  logic [7:0]          cfg_data,
   input  logic                sat_clr,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [7:0]          out_data,
   output logic                sat_flag
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned TW = $clog2(LATENCY + 1);

   logic                r_ready;
   logic [LATENCY-1:0]  r_tag;
   logic [LATENCY-1:0]  w_tag_nxt;
   logic [TW-1:0]       w_inflight_nxt;
   logic [8*TAPS-1:0]   r_coeff;
   logic [7:0]          r_mem [DEPTH];
   logic [PW-1:0]       r_rd_ptr;
   logic [PW-1:0]       r_wr_ptr;
   logic [CW-1:0]       r_count;
   logic [CW-1:0]       w_count_nxt;
   logic                r_out_valid;
   logic [7:0]          r_out_data;
   logic [7:0]          w_head_nxt;
   logic                r_sat;
   logic                w_accept;
   logic                w_push;
   logic                w_pop;
   logic signed [12:0]  w_ext;
   logic signed [12:0]  w_rnd;
   logic signed [12:0]  w_q;
   logic [7:0]          w_res;
   logic                w_clamp;

   function automatic logic [TW-1:0] popcnt(input logic [LATENCY-1:0] v);
      logic [TW-1:0] n;
      n = '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
         n = n + TW'(v[i]);
      end
      return n;
   endfunction

   assign w_accept     = in_valid & r_ready;
   assign chain_sample = w_accept ? in_sample : 4'd0;
   assign chain_accum  = '0;
   assign w_push       = r_tag[LATENCY-1];
   assign w_pop        = r_out_valid & out_ready;
   assign w_tag_nxt    = {r_tag[LATENCY-2:0], w_accept};
   assign w_inflight_nxt = popcnt(w_tag_nxt);
   assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);

   assign in_ready  = r_ready;
   assign coeff_bus = r_coeff;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign sat_flag  = r_sat;

   // Round half up, then clamp to the signed 8-bit range
   always_comb begin
      w_ext   = {chain_accum_ret[11], chain_accum_ret};
      w_rnd   = w_ext + 13'(1 << (SHIFT - 1));
      w_q     = w_rnd >>> SHIFT;
      w_res   = w_q[7:0];
      w_clamp = 1'b0;
      if (w_q > 13'sd127) begin
         w_res   = 8'h7F;
         w_clamp = 1'b1;
      end else if (w_q < -13'sd128) begin
         w_res   = 8'h80;
         w_clamp = 1'b1;
      end
   end

   // Next FIFO head: bypass a push into an (about to be) empty FIFO
   always_comb begin
      w_head_nxt = r_out_data;
      if (w_pop) begin
         if (r_count == CW'(1)) begin
            if (w_push) begin
               w_head_nxt = w_res;
            end
         end else begin
            w_head_nxt = r_mem[r_rd_ptr + PW'(1)];
         end
      end else if ((r_count == '0) && w_push) begin
         w_head_nxt = w_res;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag   <= '0;
         r_ready <= 1'b0;
      end else begin
         r_tag   <= w_tag_nxt;
         r_ready <= (32'(w_count_nxt) + 32'(w_inflight_nxt)) < 32'(DEPTH);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_coeff <= '0;
      end else if (cfg_we) begin
         for (int k = 0; k < int'(TAPS); k++) begin
            if (cfg_addr == 3'(k)) begin
               r_coeff[8*k +: 8] <= cfg_data;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_res;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_rd_ptr    <= r_rd_ptr + PW'(w_pop);
         r_wr_ptr    <= r_wr_ptr + PW'(w_push);
         r_count     <= w_count_nxt;
         r_out_valid <= (w_count_nxt != '0);
         r_out_data  <= w_head_nxt;
      end
   end

   // Clear wins over a same-cycle saturating push
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sat <= 1'b0;
      end else if (sat_clr) begin
         r_sat <= 1'b0;
      end else if (w_push && w_clamp) begin
         r_sat <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Bench for fir_stream_ctrl: models the slice chain and checks outputs
// against a per-sample FIR reference computed from the accepted stream.
module tb_fir_stream_ctrl;

   localparam int unsigned TAPS    = 4;
   localparam int unsigned LATENCY = 7;
   localparam int unsigned SHIFT   = 2;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned HL      = LATENCY - 1 + TAPS;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_sample;
   logic [3:0]        chain_sample;
   logic [11:0]       chain_accum;
   logic [11:0]       chain_accum_ret;
   logic [8*TAPS-1:0] coeff_bus;
   logic              cfg_we;
   logic [2:0]        cfg_addr;
   logic [7:0]        cfg_data;
   logic              sat_clr;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        out_data;
   logic              sat_flag;

   fir_stream_ctrl #(.TAPS(TAPS), .LATENCY(LATENCY), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_sample(in_sample), .chain_sample(chain_sample), .chain_accum(chain_accum),
      .chain_accum_ret(chain_accum_ret), .coeff_bus(coeff_bus), .cfg_we(cfg_we),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .sat_clr(sat_clr),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic signed [3:0] hist [HL];
   int sm   [TAPS];
   int coef [TAPS];
   int exp_q[$];
   int got[$];
   int outstanding = 0;
   bit rdy_block   = 1'b1;
   int cyc         = 0;
   int first_pop_cyc = -1;
   int acc_cnt     = 0;

   task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: wrap to 12 bits, round half up, shift, saturate
   function automatic int model_out(input int y);
      logic [11:0] w;
      int r, q;
      w = 12'(y);
      r = int'($signed(w)) + (1 << (SHIFT - 1));
      q = r >>> SHIFT;
      if (q > 127)  q = 127;
      if (q < -128) q = -128;
      return q;
   endfunction

   // One clock: sample before the edge, then advance the chain model after it
   task automatic tick();
      logic acc, popv;
      logic signed [3:0] cs;
      int s_now, y, s;
      #1;
      acc  = in_valid & in_ready;
      popv = out_valid & out_ready;
      cs   = chain_sample;
      chk("in_ready", 32'(in_ready), (rst_n && !rdy_block && outstanding < int'(DEPTH)) ? 1 : 0);
      s_now = acc ? int'($signed(in_sample)) : 0;
      chk("chain_sample", 32'(cs), s_now);
      if (popv) begin
         total++;
         assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL out_unexpected observed=%0d expected=none", $signed(out_data));
         end
         if (exp_q.size() != 0) chk("out_data", 32'($signed(out_data)), exp_q.pop_front());
         got.push_back(int'($signed(out_data)));
         if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
      for (int k = int'(TAPS) - 1; k > 0; k--) sm[k] = sm[k-1];
      sm[0] = s_now;
      if (acc) begin
         y = 0;
         for (int k = 0; k < int'(TAPS); k++) y += coef[k] * sm[k];
         exp_q.push_back(model_out(y));
         acc_cnt++;
      end
      outstanding += (acc ? 1 : 0) - (popv ? 1 : 0);
      total++;
      assert (outstanding <= int'(DEPTH)) else begin
         bad++;
         $error("FAIL fifo_overflow observed=%0d expected<=%0d", outstanding, DEPTH);
      end
      @(posedge clk);
      cyc++;
      if (rst_n) rdy_block = 1'b0;
      #1;
      for (int j = int'(HL) - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = cs;
      s = 0;
      for (int k = 0; k < int'(TAPS); k++)
         s += int'($signed(coeff_bus[8*k +: 8])) * int'(hist[int'(LATENCY) - 1 + k]);
      chain_accum_ret = 12'(s);
   endtask

   task automatic cfg(input int addr, input int d);
      cfg_we   = 1'b1;
      cfg_addr = 3'(addr);
      cfg_data = 8'(d);
      tick();
      cfg_we   = 1'b0;
      if (addr < int'(TAPS)) coef[addr] = d;
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (outstanding > 0 && n < 300) begin
         tick();
         n++;
      end
      chk("drain_outstanding", 32'(outstanding), 0);
      repeat (HL + 2) tick();
   endtask

   initial begin
      int t0, base, guard;
      rst_n = 1'b0; in_valid = 1'b0; in_sample = '0; chain_accum_ret = '0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; sat_clr = 1'b0; out_ready = 1'b0;
      for (int j = 0; j < int'(HL); j++) hist[j] = '0;
      for (int k = 0; k < int'(TAPS); k++) begin sm[k] = 0; coef[k] = 0; end
      #2;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data",  32'(out_data), 0);
      chk("rst_sat_flag",  32'(sat_flag), 0);
      chk("rst_coeff_bus", 32'(coeff_bus), 0);
      chk("rst_in_ready",  32'(in_ready), 0);
      chk("chain_accum",   32'(chain_accum), 0);
      repeat (3) tick();
      rst_n = 1'b1;
      drain();

      // Impulse
      cfg(0, 10); cfg(1, 20); cfg(2, -30); cfg(3, 40);
      chk("coeff_bus_load", 32'(coeff_bus), 32'h28E2140A);
      got.delete(); first_pop_cyc = -1; base = acc_cnt;
      out_ready = 1'b1; in_valid = 1'b1; in_sample = 4'd7;
      t0 = cyc;
      tick();
      in_sample = 4'd0;
      repeat (11) tick();
      drain();
      chk("impulse_latency", 32'(first_pop_cyc - t0), 8);
      chk("impulse_y0", 32'(got[0]), 18);
      chk("impulse_y1", 32'(got[1]), 35);
      chk("impulse_y2", 32'(got[2]), -52);
      chk("impulse_y3", 32'(got[3]), 70);
      chk("impulse_y4", 32'(got[4]), 0);
      chk("impulse_count", 32'(got.size()), acc_cnt - base);
      chk("impulse_sat", 32'(sat_flag), 0);

      // Saturation and sticky flag
      cfg(0, 127); cfg(1, 0); cfg(2, 0); cfg(3, 0);
      got.delete();
      in_valid = 1'b1; in_sample = 4'd7; tick();
      in_sample = 4'h8; tick();
      drain();
      chk("sat_hi", 32'(got[0]), 127);
      chk("sat_lo", 32'(got[1]), -128);
      chk("sat_flag_set", 32'(sat_flag), 1);
      sat_clr = 1'b1; tick(); sat_clr = 1'b0;
      chk("sat_flag_clr", 32'(sat_flag), 0);
      sat_clr = 1'b1; in_valid = 1'b1; in_sample = 4'd7; tick();
      in_valid = 1'b0;
      repeat (10) tick();
      sat_clr = 1'b0;
      chk("sat_clr_priority", 32'(sat_flag), 0);
      drain();

      // Backpressure
      got.delete(); base = acc_cnt;
      out_ready = 1'b0; in_valid = 1'b1;
      repeat (12) begin in_sample = 4'($urandom); tick(); end
      chk("bp_accepted", 32'(acc_cnt - base), 4);
      chk("bp_in_ready", 32'(in_ready), 0);
      drain();
      chk("bp_outputs", 32'(got.size()), 4);
      chk("bp_ready_back", 32'(in_ready), 1);

      // Reset with three entries waiting in the FIFO
      out_ready = 1'b0; in_valid = 1'b1; in_sample = 4'd3;
      repeat (3) tick();
      in_valid = 1'b0;
      repeat (9) tick();
      chk("pre_rst_out_valid", 32'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 0);
      chk("mid_rst_in_ready",  32'(in_ready), 0);
      chk("mid_rst_coeff_bus", 32'(coeff_bus), 0);
      exp_q.delete(); outstanding = 0; rdy_block = 1'b1;
      for (int k = 0; k < int'(TAPS); k++) begin sm[k] = 0; coef[k] = 0; end
      repeat (2) tick();
      rst_n = 1'b1; out_ready = 1'b1;
      repeat (15) begin
         tick();
         chk("post_rst_idle", 32'(out_valid), 0);
      end

      // Coefficient address guard
      cfg(5, 8'h55);
      chk("addr_guard", 32'(coeff_bus), 0);
      cfg(2, 8'h7B);
      chk("addr2_byte", 32'(coeff_bus[23:16]), 8'h7B);
      chk("addr2_bus", 32'(coeff_bus), 32'h007B0000);

      // Gapped random stream with random backpressure
      for (int k = 0; k < int'(TAPS); k++) cfg(k, int'($urandom_range(0, 255)) - 128);
      drain();
      base = acc_cnt; guard = 0;
      while ((acc_cnt - base) < 200 && guard < 4000) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_sample = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
         guard++;
      end
      chk("rand_progress", 32'(acc_cnt - base), 200);
      drain();
      chk("rand_queue_empty", 32'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
